crtc_mode_loader: RTL

- Sequencer that programs the 6845-style CRTC register file from built-in mode tables.
- Sits between the CPU-side CRTC port (3D4/3D5 or 3B4/3B5 decode) and the CRTC bus pins: ENABLE, nCS, R_nW, RS, DI.
- Owns the CRTC bus while loading; stalls CPU accesses meanwhile.
- Restores the CPU's last selected register index afterwards, so the mode switch is invisible to software.

---
 rtl/crtc_mode_loader.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/crtc_mode_loader.sv
// CRTC mode loader: writes a built-in mode table into a 6845-style CRTC.
// Optional vblank-synchronised start: define CRTC_MODE_LOADER_VBLANK_SYNC_EN.
module crtc_mode_loader #(
    parameter int NUM_REGS = 16,
    parameter int GAP      = 1
) (
    input  logic       CLOCK,
    input  logic       nRESET,
    input  logic [1:0] mode_sel,
    input  logic       mode_req,
    input  logic       vblank,
    output logic       busy,
    output logic       done,
    input  logic       cpu_cs,
    input  logic       cpu_rnw,
    input  logic       cpu_rs,
    input  logic [7:0] cpu_di,
    output logic       cpu_wait,
    output logic       crtc_enable,
    output logic       crtc_ncs,
    output logic       crtc_rnw,
    output logic       crtc_rs,
    output logic [7:0] crtc_di
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_WAIT_VB,
        S_ADDR,
        S_GAP_A,
        S_DATA,
        S_GAP_D,
        S_RESTORE,
        S_GAP_R,
        S_DONE
    } state_t;

    localparam logic [95:0] M0 = 96'h61_50_52_0F_19_06_19_19_02_0D_0B_0C;
    localparam logic [95:0] M1 = 96'h71_50_5A_0A_1F_06_19_1C_02_07_06_07;
    localparam logic [95:0] M2 = 96'h38_28_2D_0A_1F_06_19_1C_02_07_06_07;
    localparam logic [95:0] M3 = 96'h38_28_2D_0A_7F_06_64_70_02_01_06_07;

    localparam logic [2:0] GAP_LAST = (GAP > 0) ? 3'(GAP - 1) : 3'd0;
    localparam logic [3:0] CNT_LAST = 4'(NUM_REGS - 1);

    state_t     r_state;
    state_t     w_next;
    logic [2:0] r_gcnt;
    logic [3:0] r_cnt;
    logic [1:0] r_msel;
    logic [1:0] r_psel;
    logic       r_pending;
    logic [4:0] r_cpu_idx;
    logic       w_start;
    logic       w_last;
    logic       w_gap_end;
    logic       w_vb_rise;

    // Mode table ROM; R12 and up read as zero.
    function automatic logic [7:0] f_tbl(input logic [1:0] m,
                                         input logic [3:0] r);
        logic [95:0] row;
        row = M0;
        unique case (m)
            2'd0: row = M0;
            2'd1: row = M1;
            2'd2: row = M2;
            2'd3: row = M3;
        endcase
        if (r > 4'd11) return 8'h00;
        return row[8 * (11 - int'(r)) +: 8];
    endfunction

    assign w_start   = mode_req | r_pending;
    assign w_last    = (r_cnt == CNT_LAST);
    assign w_gap_end = (r_gcnt == GAP_LAST);

`ifdef CRTC_MODE_LOADER_VBLANK_SYNC_EN
    logic r_vb_prev;

    // Previous vblank sample for rising-edge detection.
    always_ff @(posedge CLOCK or negedge nRESET) begin
        if (!nRESET) r_vb_prev <= 1'b0;
        else         r_vb_prev <= vblank;
    end

    assign w_vb_rise = vblank & ~r_vb_prev;
`else
    logic w_unused_vblank;
    assign w_unused_vblank = vblank;
    assign w_vb_rise       = 1'b0;
`endif

    // Next-state logic for the load sequence.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_start) begin
`ifdef CRTC_MODE_LOADER_VBLANK_SYNC_EN
                    w_next = S_WAIT_VB;
`else
                    w_next = S_ADDR;
`endif
                end
            end
            S_WAIT_VB: if (w_vb_rise) w_next = S_ADDR;
            S_ADDR:    w_next = (GAP > 0) ? S_GAP_A : S_DATA;
            S_GAP_A:   if (w_gap_end) w_next = S_DATA;
            S_DATA: begin
                if (GAP > 0)     w_next = S_GAP_D;
                else if (w_last) w_next = S_RESTORE;
                else             w_next = S_ADDR;
            end
            S_GAP_D: begin
                if (w_gap_end) w_next = w_last ? S_RESTORE : S_ADDR;
            end
            S_RESTORE: w_next = (GAP > 0) ? S_GAP_R : S_DONE;
            S_GAP_R:   if (w_gap_end) w_next = S_DONE;
            S_DONE:    w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // Bus and status outputs; CPU passes through only when not busy.
    always_comb begin
        busy        = 1'b1;
        done        = 1'b0;
        cpu_wait    = cpu_cs;
        crtc_enable = 1'b0;
        crtc_ncs    = 1'b1;
        crtc_rnw    = 1'b1;
        crtc_rs     = 1'b0;
        crtc_di     = 8'h00;
        unique case (r_state)
            S_IDLE, S_DONE: begin
                busy        = 1'b0;
                done        = (r_state == S_DONE);
                cpu_wait    = 1'b0;
                crtc_enable = cpu_cs;
                crtc_ncs    = ~cpu_cs;
                crtc_rnw    = cpu_rnw;
                crtc_rs     = cpu_rs;
                crtc_di     = cpu_di;
            end
            S_ADDR: begin
                crtc_enable = 1'b1;
                crtc_ncs    = 1'b0;
                crtc_rnw    = 1'b0;
                crtc_di     = {4'b0, r_cnt};
            end
            S_DATA: begin
                crtc_enable = 1'b1;
                crtc_ncs    = 1'b0;
                crtc_rnw    = 1'b0;
                crtc_rs     = 1'b1;
                crtc_di     = f_tbl(r_msel, r_cnt);
            end
            S_RESTORE: begin
                crtc_enable = 1'b1;
                crtc_ncs    = 1'b0;
                crtc_rnw    = 1'b0;
                crtc_di     = {3'b0, r_cpu_idx};
            end
            default: ;
        endcase
    end

    // State register and gap timer, cleared on every state change.
    always_ff @(posedge CLOCK or negedge nRESET) begin
        if (!nRESET) begin
            r_state <= S_IDLE;
            r_gcnt  <= 3'd0;
        end else begin
            r_state <= w_next;
            r_gcnt  <= (r_state != w_next) ? 3'd0 : r_gcnt + 3'd1;
        end
    end

    // Request latching: start from IDLE, otherwise keep the last as pending.
    always_ff @(posedge CLOCK or negedge nRESET) begin
        if (!nRESET) begin
            r_msel    <= 2'd0;
            r_psel    <= 2'd0;
            r_pending <= 1'b0;
        end else if (r_state == S_IDLE) begin
            if (w_start) begin
                r_msel    <= mode_req ? mode_sel : r_psel;
                r_pending <= 1'b0;
            end
        end else if (mode_req) begin
            r_psel    <= mode_sel;
            r_pending <= 1'b1;
        end
    end

    // Register counter: cleared on start, stepped on each new ADDR.
    always_ff @(posedge CLOCK or negedge nRESET) begin
        if (!nRESET) begin
            r_cnt <= 4'd0;
        end else if (r_state == S_IDLE) begin
            r_cnt <= 4'd0;
        end else if ((r_state == S_DATA || r_state == S_GAP_D)
                     && w_next == S_ADDR) begin
            r_cnt <= r_cnt + 4'd1;
        end
    end

    // Shadow of the CPU's selected register index.
    always_ff @(posedge CLOCK or negedge nRESET) begin
        if (!nRESET) begin
            r_cpu_idx <= 5'd0;
        end else if (!busy && cpu_cs && !cpu_rnw && !cpu_rs) begin
            r_cpu_idx <= cpu_di[4:0];
        end
    end

endmodule
